// File: rtl/gost_ofb_ctrl.sv
// Output-feedback (gamma) sequencer for the gost core over one SD data block: gamma_1 = E(IV),
// gamma_i = E(gamma_{i-1}). Optional macro GAMMA_PREFETCH_EN overlaps the next E() with the XOR pass.
module gost_ofb_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic [63:0]       iiv,
    output logic              ogost_start,
    output logic [63:0]       ogost_block,
    input  logic [63:0]       igost_block,
    input  logic              igost_done,
    output logic [ADDR_W-1:0] oraddr,
    input  logic [3:0]        idata_raw,
    output logic [ADDR_W-1:0] owaddr,
    output logic [3:0]        odata,
    output logic              owrite_en,
    output logic              obusy,
    output logic              odone
);
    localparam int BW = ADDR_W - 4;
    localparam logic [BW-1:0] BLK_ONE = BW'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_XOR, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [63:0]       gamma_q, gamma_d;
    logic [BW-1:0]     blk_q, blk_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              gst_q, gst_d;
    logic [63:0]       gblk_q, gblk_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              last_blk;
    logic [ADDR_W-1:0] raddr;
    logic [3:0]        nib_idx;
    logic [5:0]        nib_lsb;
    logic [3:0]        gamma_nib;

`ifdef GAMMA_PREFETCH_EN
    logic [63:0]       gnext_q, gnext_d;
    logic              gnext_vld_q, gnext_vld_d;
    logic              next_last;
    logic [63:0]       pf_gamma;

    assign next_last = ((blk_q + BLK_ONE) == '1);
    // A result arriving in the very last XOR cycle is used directly.
    assign pf_gamma  = gnext_vld_q ? gnext_q : igost_block;
`endif

    assign last_blk  = (blk_q == '1);
    assign raddr     = (state_q == S_XOR && !cnt_q[4]) ? {blk_q, cnt_q[3:0]} : '0;
    // Write at count c uses nibble c-1, MSB nibble first; c=16 wraps to index 15.
    assign nib_idx   = cnt_q[3:0] - 4'd1;
    assign nib_lsb   = {~nib_idx, 2'b00};
    assign gamma_nib = gamma_q[nib_lsb +: 4];

    assign ogost_start = gst_q;
    assign ogost_block = gblk_q;
    assign oraddr      = raddr;
    assign owaddr      = waddr_q;
    assign owrite_en   = wen_q;
    assign odata       = wen_q ? (idata_raw ^ gamma_nib) : 4'd0;
    assign obusy       = busy_q;
    assign odone       = done_q;

    always_comb begin
        state_d = state_q;
        gamma_d = gamma_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        gst_d   = 1'b0;
        gblk_d  = gblk_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
`ifdef GAMMA_PREFETCH_EN
        gnext_d     = gnext_q;
        gnext_vld_d = gnext_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    gamma_d = iiv;
                    blk_d   = '0;
                    gst_d   = 1'b1;
                    gblk_d  = iiv;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (igost_done) begin
                    gamma_d = igost_block;
                    cnt_d   = '0;
                    state_d = S_XOR;
`ifdef GAMMA_PREFETCH_EN
                    if (!last_blk) begin
                        gst_d  = 1'b1;
                        gblk_d = igost_block;
                    end
`endif
                end
            end
            S_XOR: begin
                cnt_d = cnt_q + 5'd1;
                if (!cnt_q[4]) begin
                    wen_d   = 1'b1;
                    waddr_d = raddr;
                end
`ifdef GAMMA_PREFETCH_EN
                if (igost_done) begin
                    gnext_d     = igost_block;
                    gnext_vld_d = 1'b1;
                end
`endif
                if (cnt_q[4]) begin
                    cnt_d = '0;
                    if (last_blk) begin
                        state_d = S_DONE;
                    end else begin
                        blk_d = blk_q + BLK_ONE;
`ifdef GAMMA_PREFETCH_EN
                        if (gnext_vld_q || igost_done) begin
                            gamma_d     = pf_gamma;
                            gnext_vld_d = 1'b0;
                            state_d     = S_XOR;
                            if (!next_last) begin
                                gst_d  = 1'b1;
                                gblk_d = pf_gamma;
                            end
                        end else begin
                            state_d = S_WAIT;
                        end
`else
                        gst_d   = 1'b1;
                        gblk_d  = gamma_q;
                        state_d = S_START;
`endif
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = !(state_d == S_IDLE || state_d == S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            state_q <= S_IDLE;
            gamma_q <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            gst_q   <= 1'b0;
            gblk_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GAMMA_PREFETCH_EN
            gnext_q     <= '0;
            gnext_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gamma_q <= gamma_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            gst_q   <= gst_d;
            gblk_q  <= gblk_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GAMMA_PREFETCH_EN
            gnext_q     <= gnext_d;
            gnext_vld_q <= gnext_vld_d;
`endif
        end
    end
endmodule

// File: tb/tb_gost_ofb_ctrl.sv
// Bench for gost_ofb_ctrl: gost stub (result = ~input after L cycles), RAM models and a keystream model.
module tb_gost_ofb_ctrl;
    localparam int NNIB = 1024;
    localparam int NBLK = 64;
    localparam logic [63:0] IV1 = 64'hb97b7f467edaefd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        istart;
    logic [63:0] iiv;
    logic        ogost_start;
    logic [63:0] ogost_block;
    logic [63:0] igost_block;
    logic        igost_done;
    logic [9:0]  oraddr;
    logic [3:0]  idata_raw;
    logic [9:0]  owaddr;
    logic [3:0]  odata;
    logic        owrite_en;
    logic        obusy;
    logic        odone;

    logic [3:0]  raw_mem [NNIB];
    int          stub_lat;
    int          rem;
    logic [63:0] held_blk;
    logic [63:0] stub_res;
    logic        spur;
    int          gblk_err;
    int          done_cnt;
    int          wr_addr [$];
    logic [3:0]  wr_data [$];
    int          n_checks;
    int          n_err;
    int          op_base;

    gost_ofb_ctrl #(.ADDR_W(10)) dut (
        .iclk(clk), .irst(rst_n), .istart(istart), .iiv(iiv),
        .ogost_start(ogost_start), .ogost_block(ogost_block),
        .igost_block(igost_block), .igost_done(igost_done),
        .oraddr(oraddr), .idata_raw(idata_raw),
        .owaddr(owaddr), .odata(odata), .owrite_en(owrite_en),
        .obusy(obusy), .odone(odone)
    );

    always #5 clk = ~clk;

    // gost stub, RAM models and activity logs
    always @(posedge clk) begin
        if (!rst_n) begin
            rem      <= 0;
            stub_res <= '0;
        end else if (ogost_start) begin
            rem      <= stub_lat;
            held_blk <= ogost_block;
            stub_res <= ~ogost_block;
        end else if (rem != 0) begin
            rem <= rem - 1;
            if (ogost_block !== held_blk) gblk_err <= gblk_err + 1;
        end
        if (odone) done_cnt <= done_cnt + 1;
        if (owrite_en) begin
            wr_addr.push_back(int'(owaddr));
            wr_data.push_back(odata);
        end
        idata_raw <= raw_mem[oraddr];
    end

    assign igost_done  = (rem == 1) || spur;
    assign igost_block = stub_res;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gst"},   64'(ogost_start), 64'd0);
        check({tag, "_gblk"},  ogost_block,      64'd0);
        check({tag, "_raddr"}, 64'(oraddr),      64'd0);
        check({tag, "_waddr"}, 64'(owaddr),      64'd0);
        check({tag, "_data"},  64'(odata),       64'd0);
        check({tag, "_wen"},   64'(owrite_en),   64'd0);
        check({tag, "_busy"},  64'(obusy),       64'd0);
        check({tag, "_done"},  64'(odone),       64'd0);
    endtask

    // One full block operation; result checked against the OFB keystream model.
    task automatic run_op(input logic [63:0] iv, input int lat, input bit inject);
        int n;
        int exp_cyc;
        int done0;
        int gerr0;
        bit seen;
        logic [63:0] gam [NBLK];
        logic [63:0] g;
        logic [3:0]  e;

        gam[0] = ~iv;
        for (int b = 1; b < NBLK; b++) gam[6'(b)] = ~gam[6'(b - 1)];
`ifdef GAMMA_PREFETCH_EN
        exp_cyc = (lat + 18) + (NBLK - 1) * ((lat + 1 > 17) ? lat + 1 : 17) + 1;
`else
        exp_cyc = NBLK * (lat + 18) + 1;
`endif
        stub_lat = lat;
        op_base  = wr_addr.size();
        done0    = done_cnt;
        gerr0    = gblk_err;

        @(negedge clk);
        iiv    = iv;
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
        n = 1;
        check("start_pulse", 64'(ogost_start), 64'd1);
        check("start_busy",  64'(obusy),       64'd1);
        check("start_block", ogost_block,      iv);
        seen = 1'b0;
        while (n < 20000) begin
            if (odone) begin
                seen = 1'b1;
                break;
            end
            istart = inject && (n == 3 || n == lat + 5);
            @(negedge clk);
            n++;
        end
        istart = 1'b0;
        check("done_seen",  64'(seen),  64'd1);
        check("done_cycle", 64'(n),     64'(exp_cyc));
        check("done_busy",  64'(obusy), 64'd0);
`ifdef GAMMA_PREFETCH_EN
        if (lat == 8) check("prefetch_fast", 64'(n < NBLK * 20), 64'd1);
`endif
        @(negedge clk);
        check("idle_busy", 64'(obusy), 64'd0);
        check("done_once", 64'(done_cnt - done0), 64'd1);
        check("gblk_stable", 64'(gblk_err - gerr0), 64'd0);
        check("wr_count", 64'(wr_addr.size() - op_base), 64'(NNIB));
        for (int i = 0; i < NNIB && op_base + i < wr_addr.size(); i++) begin
            g = gam[6'(i / 16)];
            e = raw_mem[10'(i)] ^ 4'(g >> (60 - 4 * (i % 16)));
            check("wr_addr", 64'(wr_addr[op_base + i]), 64'(i));
            check("wr_data", 64'(wr_data[op_base + i]), 64'(e));
        end
    endtask

    // Known keystream of the all-zero raw block for IV1.
    task automatic check_words();
        logic [63:0] w0;
        logic [63:0] w1;
        w0 = '0;
        w1 = '0;
        check("words_avail", 64'(wr_data.size() >= op_base + 32), 64'd1);
        if (wr_data.size() >= op_base + 32) begin
            for (int k = 0; k < 16; k++) begin
                w0 = {w0[59:0], wr_data[op_base + k]};
                w1 = {w1[59:0], wr_data[op_base + 16 + k]};
            end
            check("blk0_word", w0, 64'h468480b981251027);
            check("blk1_word", w1, 64'hb97b7f467edaefd8);
        end
    endtask

    task automatic abort_run(input logic [63:0] iv);
        bit found;
        stub_lat = 32;
        @(negedge clk);
        iiv    = iv;
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
        found  = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            if (owrite_en && owaddr[9:4] == 6'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reach", 64'(found), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle_busy", 64'(obusy),       64'd0);
        check("abort_idle_gst",  64'(ogost_start), 64'd0);
        check("abort_idle_wen",  64'(owrite_en),   64'd0);
    endtask

    initial begin
        int nwr;
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        istart   = 1'b0;
        iiv      = '0;
        spur     = 1'b0;
        stub_lat = 32;
        for (int i = 0; i < NNIB; i++) raw_mem[10'(i)] = 4'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // spurious gost completion while idle
        nwr  = wr_addr.size();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        check("spur_busy", 64'(obusy),       64'd0);
        check("spur_gst",  64'(ogost_start), 64'd0);
        check("spur_wr",   64'(wr_addr.size()), 64'(nwr));

        // zero raw block, fixed IV
        run_op(IV1, 32, 1'b0);
        check_words();

        // raw nibble n = n[3:0]
        for (int i = 0; i < NNIB; i++) raw_mem[10'(i)] = 4'(i);
        run_op(IV1, 32, 1'b0);

        // random data, IV and latency
        for (int i = 0; i < NNIB; i++) raw_mem[10'(i)] = 4'($urandom);
        run_op({$urandom, $urandom}, int'($urandom_range(2, 40)), 1'b0);

        // istart pulses during WAIT and XOR must be ignored
        run_op({$urandom, $urandom}, 8, 1'b1);

        // reset during block 5 then a clean rerun
        for (int i = 0; i < NNIB; i++) raw_mem[10'(i)] = 4'd0;
        abort_run(IV1);
        run_op(IV1, 32, 1'b0);
        check_words();

        // short and long gost latency
        run_op(IV1, 8, 1'b0);
        check_words();
        run_op(IV1, 40, 1'b0);
        check_words();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
